// File: rtl/fir_out_serializer.sv
// Requantizes each 4-lane FIR output word (round half up, drop LSBs, saturate),
// buffers up to two words, and streams the samples out lane 0 first.
module fir_out_serializer #(
  parameter int NB_DATA_IN  = 19,
  parameter int NB_DATA_OUT = 8,
  parameter int NB_DROP     = 7
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic [NB_DATA_IN-1:0]  i_data_0,
  input  logic [NB_DATA_IN-1:0]  i_data_1,
  input  logic [NB_DATA_IN-1:0]  i_data_2,
  input  logic [NB_DATA_IN-1:0]  i_data_3,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [NB_DATA_OUT-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_overflow
);

  localparam logic signed [NB_DATA_IN:0] RND   = (NB_DATA_IN+1)'(1) << (NB_DROP - 1);
  localparam logic signed [NB_DATA_IN:0] W_MAX = (NB_DATA_IN+1)'(2**(NB_DATA_OUT-1) - 1);
  localparam logic signed [NB_DATA_IN:0] W_MIN = ~W_MAX;
  localparam logic [NB_DATA_OUT-1:0]     O_MAX = {1'b0, {(NB_DATA_OUT-1){1'b1}}};
  localparam logic [NB_DATA_OUT-1:0]     O_MIN = {1'b1, {(NB_DATA_OUT-1){1'b0}}};

  logic [NB_DATA_IN-1:0]             lane_in [4];
  logic signed [NB_DATA_IN:0]        sum;
  logic signed [NB_DATA_IN:0]        shr;
  logic [3:0][NB_DATA_OUT-1:0]       q_word;
  logic                              q_clip;

  logic [3:0][NB_DATA_OUT-1:0]       mem [2];
  logic                              wr_ptr;
  logic                              rd_ptr;
  logic [1:0]                        count;
  logic [1:0]                        lane_ptr;
  logic                              ovf_q;

  logic                              push;
  logic                              pop_lane;
  logic                              pop_word;

  assign lane_in[0] = i_data_0;
  assign lane_in[1] = i_data_1;
  assign lane_in[2] = i_data_2;
  assign lane_in[3] = i_data_3;

  // One guard bit on the add keeps the rounding offset from wrapping at +full-scale.
  always_comb begin
    sum    = '0;
    shr    = '0;
    q_word = '0;
    q_clip = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      sum = $signed({lane_in[k][NB_DATA_IN-1], lane_in[k]}) + RND;
      shr = sum >>> NB_DROP;
      if (shr > W_MAX) begin
        q_word[k] = O_MAX;
        q_clip    = 1'b1;
      end else if (shr < W_MIN) begin
        q_word[k] = O_MIN;
        q_clip    = 1'b1;
      end else begin
        q_word[k] = shr[NB_DATA_OUT-1:0];
      end
    end
  end

  assign o_ready    = i_reset && (count != 2'd2);
  assign o_valid    = i_reset && (count != 2'd0);
  assign o_data     = o_valid ? mem[rd_ptr][lane_ptr] : '0;
  assign o_overflow = i_reset && ovf_q;

  assign push     = i_valid && o_ready;
  assign pop_lane = o_valid && i_ready;
  assign pop_word = pop_lane && (lane_ptr == 2'd3);

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      lane_ptr <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= q_word;
        wr_ptr      <= ~wr_ptr;
        if (q_clip) ovf_q <= 1'b1;
      end
      if (pop_lane) lane_ptr <= lane_ptr + 2'd1;
      if (pop_word) rd_ptr <= ~rd_ptr;
      case ({push, pop_word})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_out_serializer.sv
// Self-checking bench: directed scenarios then random traffic, compared against
// a sample-queue reference model of the serializer.
module tb_fir_out_serializer;

  localparam int NI = 19;
  localparam int NO = 8;
  localparam int ND = 7;

  logic          clock;
  logic          i_reset;
  logic [NI-1:0] i_data_0, i_data_1, i_data_2, i_data_3;
  logic          i_valid;
  logic          o_ready;
  logic [NO-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_overflow;

  fir_out_serializer #(.NB_DATA_IN(NI), .NB_DATA_OUT(NO), .NB_DROP(ND)) dut (
    .clock(clock), .i_reset(i_reset),
    .i_data_0(i_data_0), .i_data_1(i_data_1), .i_data_2(i_data_2), .i_data_3(i_data_3),
    .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_overflow(o_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_asserts = 0;
  int n_fail    = 0;
  int samples[$];
  bit ovf_model = 0;
  int lane[4];

  // Round half up by floor division, then clamp to the output range.
  function automatic int quant(input int x, output bit clip);
    int den, num, r, hi, lo;
    den  = 1 << ND;
    num  = x + den / 2;
    r    = num / den;
    if ((num % den != 0) && (num < 0)) r = r - 1;
    hi   = (1 << (NO - 1)) - 1;
    lo   = -(1 << (NO - 1));
    clip = 0;
    if (r > hi) begin r = hi; clip = 1; end
    if (r < lo) begin r = lo; clip = 1; end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int a, input int b, input int c, input int d);
    lane[0] = a; lane[1] = b; lane[2] = c; lane[3] = d;
    i_data_0 = NI'(a); i_data_1 = NI'(b); i_data_2 = NI'(c); i_data_3 = NI'(d);
  endtask

  // Check outputs against the model before the edge, then advance the model by one edge.
  task automatic tick();
    int   words, head;
    bit   clip;
    logic exp_ready, exp_valid;
    logic [NO-1:0] exp_data;
    #1;
    words     = (samples.size() + 3) / 4;
    exp_ready = i_reset && (words < 2);
    exp_valid = i_reset && (samples.size() > 0);
    head      = (samples.size() > 0) ? samples[0] : 0;
    exp_data  = exp_valid ? NO'(head) : '0;
    chk("o_ready", 32'(o_ready), 32'(exp_ready));
    chk("o_valid", 32'(o_valid), 32'(exp_valid));
    chk("o_data", 32'(o_data), 32'(exp_data));
    chk("o_overflow", 32'(o_overflow), 32'(i_reset && ovf_model));
    if (!i_reset) begin
      samples.delete();
      ovf_model = 0;
    end else begin
      if (exp_valid && i_ready) void'(samples.pop_front());
      if (i_valid && exp_ready) begin
        for (int k = 0; k < 4; k++) begin
          samples.push_back(quant(lane[k], clip));
          if (clip) ovf_model = 1;
        end
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
    set_word(5, 6, 7, 8);

    // Reset held with i_valid asserted; ready appears right after release.
    repeat (3) tick();
    i_reset = 1'b1; i_valid = 1'b0;
    tick();

    // Rounding.
    set_word(128, -192, 63, 64); i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (6) tick();

    // Saturation, then a clean word; overflow must stay set.
    set_word(262143, -262144, 8191, -8256); i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (4) tick();
    set_word(300, -300, 0, 1000); i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (5) tick();

    // Fill with backpressure, refused third word, stall mid-word, drain.
    i_ready = 1'b0;
    set_word(1000, 2000, 3000, 4000); i_valid = 1'b1; tick();
    set_word(-1000, -2000, -3000, -4000); tick();
    set_word(777, 777, 777, 777); tick();
    i_valid = 1'b0;
    i_ready = 1'b1; repeat (2) tick();
    i_ready = 1'b0; repeat (3) tick();
    i_ready = 1'b1; repeat (8) tick();

    // Push on the lane-3 pop: no bubble.
    set_word(640, 1280, 1920, 2560); i_valid = 1'b1; tick();
    i_valid = 1'b0; repeat (3) tick();
    set_word(-640, -1280, -1920, -2560); i_valid = 1'b1; tick();
    i_valid = 1'b0; repeat (5) tick();

    // Reset while emitting lane 2 with a second word queued.
    set_word(100, 200, 300, 400); i_valid = 1'b1; tick();
    set_word(500, 600, 700, 800); tick();
    i_valid = 1'b0; tick();
    i_reset = 1'b0; tick();
    i_reset = 1'b1; tick();
    set_word(-100, -200, -300, -400); i_valid = 1'b1; tick();
    i_valid = 1'b0; repeat (5) tick();

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1)
        set_word(int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 524287)) - 262144,
                 int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 524287)) - 262144);
      else
        set_word(int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 40000)) - 20000,
                 int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 40000)) - 20000);
      i_valid = ($urandom_range(0, 2) == 0);
      i_ready = ($urandom_range(0, 3) != 0);
      i_reset = ($urandom_range(0, 63) != 0);
      tick();
    end
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_out_serializer.md
Name: fir_out_serializer

Overview:
Output stage directly downstream of the 4-lane parallel FIR. Each cycle it can accept one 4-lane word of full-precision filter outputs and requantize each lane: round half up, drop LSBs, then saturate. Words are buffered in a 2-word FIFO and emitted as one sample per cycle, lane 0 first, over a valid/ready stream. Net effect: the 4x-parallel filter output becomes a single-rate sample stream for DAC/serial consumers.

Parameters:
NB_DATA_IN, 19, width of each input lane; equals the FIR output width.
NB_DATA_OUT, 8, width of each output sample.
NB_DROP, 7, LSBs discarded by rounding; must be >= 1.

Ports:
clock  input  1  system clock; all logic on the rising edge.
i_reset  input  1  synchronous, active-low reset.
i_data_0  input  NB_DATA_IN  signed lane 0, oldest sample in time.
i_data_1  input  NB_DATA_IN  signed lane 1.
i_data_2  input  NB_DATA_IN  signed lane 2.
i_data_3  input  NB_DATA_IN  signed lane 3, newest sample in time.
i_valid  input  1  the 4-lane word is valid this cycle.
o_ready  output  1  block can accept a word; a write occurs when i_valid && o_ready.
o_data  output  NB_DATA_OUT  signed serialized sample.
o_valid  output  1  o_data is valid.
i_ready  input  1  downstream accepts; a transfer occurs when o_valid && i_ready.
o_overflow  output  1  sticky flag: at least one saturation has occurred since reset.

Behaviour:
- Reset: clock is clock; reset i_reset is synchronous and active-low.
  - While i_reset==0: FIFO count=0, write/read pointers=0, lane pointer=0, o_valid=0, o_data=0, o_overflow=0, o_ready=0.
  - o_ready rises on the first cycle after i_reset returns high.
- Quantization happens at the write, per lane:
  - r = (x + 2^(NB_DROP-1)) >>> NB_DROP, using NB_DATA_IN+1-bit arithmetic so the add cannot wrap.
  - Clamp r to [-2^(NB_DATA_OUT-1), 2^(NB_DATA_OUT-1)-1].
  - Store 4*NB_DATA_OUT bits per word.
- Overflow: if any lane of an accepted word clamps, o_overflow goes to 1 on the next edge and holds until reset.
- FIFO: depth 2 words, registered storage.
  - o_ready = (count<2) && i_reset.
  - o_ready is purely registered-state based; there is no combinational path from i_ready.
  - When full, o_ready=0 even if a pop occurs in the same cycle.
- Output path:
  - o_valid = (count>0).
  - o_data = head word lane[lane_ptr], driven from registers; o_data=0 when empty.
- Latency: a word written at edge N gives o_valid=1 with lane 0 in cycle N+1.
- On each transfer:
  - lane_ptr increments.
  - On the lane-3 transfer, lane_ptr returns to 0, the head word is popped and the read pointer wraps mod 2.
- Backpressure: while o_valid && !i_ready, o_data and lane_ptr hold stable.
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - The next word's lane 0 appears the next cycle with no bubble.
- Throughput: 1 sample per cycle out. Sustained input must be at most 1 word per 4 cycles; excess input is throttled via o_ready, and upstream (the FIR i_enable) must stall.
- i_valid while o_ready==0: nothing is written and no state changes.
- Reset mid-stream: buffered words are discarded and the block returns to the reset values above.

Test Plan:
1. Reset: hold i_reset=0 for 3 cycles with i_valid=1 -> o_valid=0, o_data=0, o_overflow=0, o_ready=0 throughout; o_ready=1 the cycle after release.
2. Rounding: write lanes {128,-192,63,64} once, i_ready=1 -> o_data 1, -1 (0xFF), 0, 1 on cycles N+1..N+4, o_valid low at N+5, o_overflow stays 0.
3. Saturation: write {262143,-262144,8191,-8256} -> o_data 127, -128, 64, -64 (0x7F, 0x80, 0x40, 0xC0); o_overflow=1 from N+1 and stays 1 after a later clean word.
4. Backpressure and full: write two words back to back with i_ready=0 -> o_ready=0 after the second write; a third i_valid is not accepted. Drop i_ready low for 3 cycles mid-word -> o_data held constant. Release -> 8 samples emitted in order, o_ready=1 after the first word pops.
5. Push on pop: count=1, lane 3 transfer in the same cycle as a new write -> next cycle o_valid stays 1 with the new word's lane 0, no bubble, count=1.
6. Reset mid-operation: assert i_reset for 1 cycle while emitting lane 2 with one word queued -> o_valid=0 next cycle, the queued word is lost, the next written word starts at lane 0.
